edge_stream_formatter: RTL and testbench

Back-end formatter for the streaming edge-detection path. Consumes the unsigned gradient-magnitude stream produced by `convolution`, tracks raster position, zeroes border pixels whose 3x3 window is invalid, saturates to pixel width, optionally thresholds, and emits a framed pixel stream with start-of-frame, end-of-line and end-of-frame markers toward the display/frame-buffer writer.

---
 rtl/conv_stream_pkg.sv | 27 ++
 rtl/edge_stream_formatter_if.sv | 32 +++
 rtl/raster_counter.sv | 68 ++++++
 rtl/edge_stream_formatter.sv | 163 ++++++++++++++++
 tb/tb_edge_stream_formatter.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/conv_stream_pkg.sv
// Shared parameters, state encoding and pixel record for the streaming edge-detection path.
// Used by the formatter, the convolution stage and the upstream pixel source.
package conv_stream_pkg;

   localparam int DATA_WIDTH      = 12;
   localparam int IMG_WIDTH       = 640;
   localparam int IMG_HEIGHT      = 480;
   localparam int KERNEL_SIZE     = 3;
   localparam int BORDER          = KERNEL_SIZE - 1;
   localparam int COL_WIDTH       = $clog2(IMG_WIDTH);
   localparam int ROW_WIDTH       = $clog2(IMG_HEIGHT);
   localparam int FRAME_CNT_WIDTH = 16;

   typedef enum logic [0:0] {
      S_IDLE   = 1'b0,
      S_ACTIVE = 1'b1
   } fmt_state_e;

   typedef struct packed {
      logic                  valid;
      logic                  sof;
      logic                  eol;
      logic                  eof;
      logic [DATA_WIDTH-1:0] value;
   } pixel_t;

endpackage

// File: rtl/edge_stream_formatter_if.sv
// Magnitude-in / framed-pixel-out bundle of the edge stream formatter.
interface edge_stream_formatter_if #(
   parameter int DATA_WIDTH = conv_stream_pkg::DATA_WIDTH,
   parameter int IMG_WIDTH  = conv_stream_pkg::IMG_WIDTH,
   parameter int IMG_HEIGHT = conv_stream_pkg::IMG_HEIGHT
);

   logic                          i_val_valid;
   logic [DATA_WIDTH+2:0]         i_val;
   logic                          i_frame_restart;
   logic                          i_thresh_en;
   logic [DATA_WIDTH-1:0]         i_threshold;
   logic                          o_pix_valid;
   logic [DATA_WIDTH-1:0]         o_pix;
   logic [$clog2(IMG_WIDTH)-1:0]  o_x;
   logic [$clog2(IMG_HEIGHT)-1:0] o_y;
   logic                          o_sof;
   logic                          o_eol;
   logic                          o_eof;
   logic [15:0]                   o_frame_count;

   modport master (
      output i_val_valid, i_val, i_frame_restart, i_thresh_en, i_threshold,
      input  o_pix_valid, o_pix, o_x, o_y, o_sof, o_eol, o_eof, o_frame_count
   );

   modport slave (
      input  i_val_valid, i_val, i_frame_restart, i_thresh_en, i_threshold,
      output o_pix_valid, o_pix, o_x, o_y, o_sof, o_eol, o_eof, o_frame_count
   );

endinterface

// File: rtl/raster_counter.sv
// Column/row raster position with enable and clear. Outputs describe the pixel being
// accepted this cycle (clear already applied), so callers can decode markers directly.
module raster_counter #(
   parameter int IMG_WIDTH  = conv_stream_pkg::IMG_WIDTH,
   parameter int IMG_HEIGHT = conv_stream_pkg::IMG_HEIGHT
) (
   input  logic                          i_clk,
   input  logic                          i_rst,
   input  logic                          i_en,
   input  logic                          i_clr,
   output logic [$clog2(IMG_WIDTH)-1:0]  o_col,
   output logic [$clog2(IMG_HEIGHT)-1:0] o_row,
   output logic                          o_last_col,
   output logic                          o_last_row,
   output logic                          o_wrap
);

   localparam int CW = $clog2(IMG_WIDTH);
   localparam int RW = $clog2(IMG_HEIGHT);

   logic [CW-1:0] col_r;
   logic [RW-1:0] row_r;
   logic [CW-1:0] cur_col_s;
   logic [RW-1:0] cur_row_s;
   logic [CW-1:0] col_nxt_s;
   logic [RW-1:0] row_nxt_s;
   logic          last_col_s;
   logic          last_row_s;

   // Current position (clear wins) and the position after this pixel
   always_comb begin
      cur_col_s  = i_clr ? {CW{1'b0}} : col_r;
      cur_row_s  = i_clr ? {RW{1'b0}} : row_r;
      last_col_s = (cur_col_s == CW'(IMG_WIDTH - 1));
      last_row_s = (cur_row_s == RW'(IMG_HEIGHT - 1));
      col_nxt_s  = cur_col_s;
      row_nxt_s  = cur_row_s;
      if (i_en) begin
         if (last_col_s) begin
            col_nxt_s = {CW{1'b0}};
            row_nxt_s = last_row_s ? {RW{1'b0}} : (cur_row_s + RW'(1));
         end else begin
            col_nxt_s = cur_col_s + CW'(1);
         end
      end else begin
         col_nxt_s = cur_col_s;
         row_nxt_s = cur_row_s;
      end
   end

   // Position registers
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         col_r <= {CW{1'b0}};
         row_r <= {RW{1'b0}};
      end else begin
         col_r <= col_nxt_s;
         row_r <= row_nxt_s;
      end
   end

   assign o_col      = cur_col_s;
   assign o_row      = cur_row_s;
   assign o_last_col = last_col_s;
   assign o_last_row = last_row_s;
   assign o_wrap     = i_en & last_col_s & last_row_s;

endmodule

// File: rtl/edge_stream_formatter.sv
// Formats the gradient-magnitude stream: border masking, saturation, optional threshold,
// and frame markers, with every output registered one cycle behind the input.
module edge_stream_formatter #(
   parameter int DATA_WIDTH = conv_stream_pkg::DATA_WIDTH,
   parameter int IMG_WIDTH  = conv_stream_pkg::IMG_WIDTH,
   parameter int IMG_HEIGHT = conv_stream_pkg::IMG_HEIGHT,
   parameter int BORDER     = conv_stream_pkg::BORDER
) (
   input  logic                   i_clk,
   input  logic                   i_rst,
   edge_stream_formatter_if.slave bus
);

   import conv_stream_pkg::*;

   localparam int CW = $clog2(IMG_WIDTH);
   localparam int RW = $clog2(IMG_HEIGHT);

   function automatic logic [DATA_WIDTH-1:0] saturate(input logic [DATA_WIDTH+2:0] mag);
      logic [DATA_WIDTH-1:0] res;
      if (|mag[DATA_WIDTH+2:DATA_WIDTH]) begin
         res = {DATA_WIDTH{1'b1}};
      end else begin
         res = mag[DATA_WIDTH-1:0];
      end
      return res;
   endfunction

   logic [CW-1:0]         col_s;
   logic [RW-1:0]         row_s;
   logic                  last_col_s;
   logic                  last_row_s;
   logic                  frame_done_s;
   fmt_state_e            state_r;
   fmt_state_e            state_s;
   fmt_state_e            eff_state_s;
   logic [DATA_WIDTH-1:0] sat_s;
   logic [DATA_WIDTH-1:0] thr_s;
   logic [DATA_WIDTH-1:0] pix_s;
   logic                  border_s;

   logic                  pix_valid_r;
   logic [DATA_WIDTH-1:0] pix_r;
   logic [CW-1:0]         x_r;
   logic [RW-1:0]         y_r;
   logic                  sof_r;
   logic                  eol_r;
   logic                  eof_r;
   logic [15:0]           frame_count_r;

   raster_counter #(
      .IMG_WIDTH  (IMG_WIDTH),
      .IMG_HEIGHT (IMG_HEIGHT)
   ) u_raster (
      .i_clk      (i_clk),
      .i_rst      (i_rst),
      .i_en       (bus.i_val_valid),
      .i_clr      (bus.i_frame_restart),
      .o_col      (col_s),
      .o_row      (row_s),
      .o_last_col (last_col_s),
      .o_last_row (last_row_s),
      .o_wrap     (frame_done_s)
   );

   // State register
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_r <= S_IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Next state; a restart drops back to idle before the same-cycle pixel is considered
   always_comb begin
      eff_state_s = bus.i_frame_restart ? S_IDLE : state_r;
      state_s     = eff_state_s;
      case (eff_state_s)
         S_IDLE: begin
            if (bus.i_val_valid && !frame_done_s) begin
               state_s = S_ACTIVE;
            end else begin
               state_s = S_IDLE;
            end
         end
         S_ACTIVE: begin
            if (frame_done_s) begin
               state_s = S_IDLE;
            end else begin
               state_s = S_ACTIVE;
            end
         end
         default: state_s = S_IDLE;
      endcase
   end

   // Pixel value: saturate, optional threshold, then border mask
   always_comb begin
      sat_s = saturate(bus.i_val);
      if (bus.i_thresh_en) begin
         thr_s = (sat_s >= bus.i_threshold) ? {DATA_WIDTH{1'b1}} : {DATA_WIDTH{1'b0}};
      end else begin
         thr_s = sat_s;
      end
      border_s = (col_s < CW'(BORDER)) || (row_s < RW'(BORDER));
      if (border_s) begin
         pix_s = {DATA_WIDTH{1'b0}};
      end else begin
         pix_s = thr_s;
      end
   end

   // Output stage; everything but the frame count is zero on empty cycles
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         pix_valid_r <= 1'b0;
         pix_r       <= {DATA_WIDTH{1'b0}};
         x_r         <= {CW{1'b0}};
         y_r         <= {RW{1'b0}};
         sof_r       <= 1'b0;
         eol_r       <= 1'b0;
         eof_r       <= 1'b0;
      end else if (bus.i_val_valid) begin
         pix_valid_r <= 1'b1;
         pix_r       <= pix_s;
         x_r         <= col_s;
         y_r         <= row_s;
         sof_r       <= (col_s == {CW{1'b0}}) && (row_s == {RW{1'b0}});
         eol_r       <= last_col_s;
         eof_r       <= last_col_s & last_row_s;
      end else begin
         pix_valid_r <= 1'b0;
         pix_r       <= {DATA_WIDTH{1'b0}};
         x_r         <= {CW{1'b0}};
         y_r         <= {RW{1'b0}};
         sof_r       <= 1'b0;
         eol_r       <= 1'b0;
         eof_r       <= 1'b0;
      end
   end

   // Completed-frame counter
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         frame_count_r <= 16'd0;
      end else if (frame_done_s) begin
         frame_count_r <= frame_count_r + 16'd1;
      end else begin
         frame_count_r <= frame_count_r;
      end
   end

   assign bus.o_pix_valid   = pix_valid_r;
   assign bus.o_pix         = pix_r;
   assign bus.o_x           = x_r;
   assign bus.o_y           = y_r;
   assign bus.o_sof         = sof_r;
   assign bus.o_eol         = eol_r;
   assign bus.o_eof         = eof_r;
   assign bus.o_frame_count = frame_count_r;

endmodule

// File: tb/tb_edge_stream_formatter.sv
// Scoreboard bench for edge_stream_formatter on an 8x4 image with a 2-pixel border.
module tb_edge_stream_formatter;

   typedef struct {
      logic [11:0] pix;
      logic [2:0]  x;
      logic [1:0]  y;
      logic        sof;
      logic        eol;
      logic        eof;
      logic [15:0] fc;
   } exp_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   bit   mon_en = 1'b0;
   int   n_cmp = 0;
   int   n_fail = 0;
   int   mcol = 0;
   int   mrow = 0;
   int   mfc = 0;
   exp_t q[$];

   edge_stream_formatter_if #(.DATA_WIDTH(12), .IMG_WIDTH(8), .IMG_HEIGHT(4)) bus ();

   edge_stream_formatter #(
      .DATA_WIDTH (12),
      .IMG_WIDTH  (8),
      .IMG_HEIGHT (4),
      .BORDER     (2)
   ) dut (
      .i_clk (clk),
      .i_rst (rst),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Drive one valid pixel and queue its expected response
   task automatic send(input logic [14:0] v, input logic [11:0] e_in, input logic [11:0] e_bd,
                       input bit rs, input bit ten, input logic [11:0] thr);
      exp_t e;
      @(posedge clk); #1;
      bus.i_val_valid     = 1'b1;
      bus.i_val           = v;
      bus.i_frame_restart = rs;
      bus.i_thresh_en     = ten;
      bus.i_threshold     = thr;
      if (rs) begin
         mcol = 0;
         mrow = 0;
      end
      e.x   = 3'(mcol);
      e.y   = 2'(mrow);
      e.pix = (mcol < 2 || mrow < 2) ? e_bd : e_in;
      e.sof = (mcol == 0 && mrow == 0);
      e.eol = (mcol == 7);
      e.eof = (mcol == 7 && mrow == 3);
      if (mcol == 7) begin
         mcol = 0;
         if (mrow == 3) begin
            mrow = 0;
            mfc++;
         end else begin
            mrow++;
         end
      end else begin
         mcol++;
      end
      e.fc = 16'(mfc);
      q.push_back(e);
   endtask

   task automatic idle();
      @(posedge clk); #1;
      bus.i_val_valid     = 1'b0;
      bus.i_frame_restart = 1'b0;
      bus.i_val           = 15'd0;
   endtask

   task automatic pulse_reset();
      @(posedge clk); #1;
      bus.i_val_valid     = 1'b0;
      bus.i_frame_restart = 1'b0;
      rst  = 1'b1;
      mcol = 0;
      mrow = 0;
      mfc  = 0;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check("rst_mid_valid", 32'(bus.o_pix_valid), 32'd0);
      check("rst_mid_fc", 32'(bus.o_frame_count), 32'd0);
   endtask

   // Monitor: pop and compare on every valid output, require zeros otherwise
   always @(negedge clk) begin
      exp_t e;
      if (mon_en) begin
         if (bus.o_pix_valid) begin
            if (q.size() == 0) begin
               n_cmp++;
               n_fail++;
               $display("FAIL unexpected_valid: got valid at (%0d,%0d) expected none at %0t",
                        bus.o_x, bus.o_y, $time);
            end else begin
               e = q.pop_front();
               check("pix", 32'(bus.o_pix), 32'(e.pix));
               check("x", 32'(bus.o_x), 32'(e.x));
               check("y", 32'(bus.o_y), 32'(e.y));
               check("sof", 32'(bus.o_sof), 32'(e.sof));
               check("eol", 32'(bus.o_eol), 32'(e.eol));
               check("eof", 32'(bus.o_eof), 32'(e.eof));
               check("frame_count", 32'(bus.o_frame_count), 32'(e.fc));
            end
         end else begin
            check("idle_zero", 32'({bus.o_pix, bus.o_x, bus.o_y, bus.o_sof, bus.o_eol, bus.o_eof}),
                  32'd0);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [14:0] v;
      logic [11:0] ev;
      int x;
      int y;
      bus.i_val_valid     = 1'b0;
      bus.i_val           = 15'd0;
      bus.i_frame_restart = 1'b0;
      bus.i_thresh_en     = 1'b0;
      bus.i_threshold     = 12'd0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("reset_valid", 32'(bus.o_pix_valid), 32'd0);
      check("reset_outputs", 32'({bus.o_pix, bus.o_x, bus.o_y, bus.o_sof, bus.o_eol, bus.o_eof}), 32'd0);
      check("reset_fc", 32'(bus.o_frame_count), 32'd0);
      @(posedge clk); #1;
      rst    = 1'b0;
      mon_en = 1'b1;

      // Full frame of constant magnitude
      for (int p = 0; p < 32; p++) send(15'd100, 12'd100, 12'd0, 1'b0, 1'b0, 12'd0);
      idle();
      @(negedge clk);
      check("frame1_count", 32'(bus.o_frame_count), 32'd1);

      // Saturation on the last row
      for (int p = 0; p < 32; p++) begin
         case (p)
            27:      begin v = 15'h1FFF; ev = 12'd4095; end
            28:      begin v = 15'd4095; ev = 12'd4095; end
            29:      begin v = 15'd4096; ev = 12'd4095; end
            30:      begin v = 15'h7FFF; ev = 12'd4095; end
            31:      begin v = 15'd4094; ev = 12'd4094; end
            default: begin v = 15'd7;    ev = 12'd7;    end
         endcase
         send(v, ev, 12'd0, 1'b0, 1'b0, 12'd0);
      end
      idle();

      // Thresholding at 200; border pixels carry 500 and must stay masked
      for (int p = 0; p < 32; p++) begin
         x = p % 8;
         y = p / 8;
         if (x < 2 || y < 2) begin
            v = 15'd500; ev = 12'd0;
         end else if (p == 26) begin
            v = 15'h7FFF; ev = 12'd4095;
         end else if (x % 2 == 0) begin
            v = 15'd199; ev = 12'd0;
         end else begin
            v = 15'd200; ev = 12'd4095;
         end
         send(v, ev, 12'd0, 1'b0, 1'b1, 12'd200);
      end
      idle();
      bus.i_thresh_en = 1'b0;

      // Valid every other cycle
      for (int p = 0; p < 32; p++) begin
         send(15'd50, 12'd50, 12'd0, 1'b0, 1'b0, 12'd0);
         idle();
      end

      // Restart together with the valid at (5,2)
      for (int p = 0; p < 21; p++) send(15'd100, 12'd100, 12'd0, 1'b0, 1'b0, 12'd0);
      send(15'd100, 12'd100, 12'd0, 1'b1, 1'b0, 12'd0);
      for (int p = 0; p < 31; p++) send(15'd100, 12'd100, 12'd0, 1'b0, 1'b0, 12'd0);
      idle();

      // Reset in the middle of a frame, then a fresh frame
      for (int p = 0; p < 10; p++) send(15'd300, 12'd300, 12'd0, 1'b0, 1'b0, 12'd0);
      pulse_reset();
      for (int p = 0; p < 32; p++) send(15'd123, 12'd123, 12'd0, 1'b0, 1'b0, 12'd0);
      idle();

      repeat (4) @(posedge clk);
      @(negedge clk);
      check("queue_drained", 32'(q.size()), 32'd0);
      check("final_fc", 32'(bus.o_frame_count), 32'd1);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
